// File: rtl/pakout_chk_if.sv
// 4-phase req/ack message channel carried from the pakout test source to its checker.
interface pakout_chk_if #(
  parameter int ASZ = 8,
  parameter int DSZ = 8
);
  logic [ASZ-1:0] i0_src;
  logic [ASZ-1:0] i0_dst;
  logic [DSZ-1:0] i0_dat;
  logic           i0_req;
  logic           i0_ack;

  modport master (output i0_src, output i0_dst, output i0_dat, output i0_req, input i0_ack);
  modport slave  (input i0_src, input i0_dst, input i0_dat, input i0_req, output i0_ack);
endinterface

// File: rtl/pakout_chk.sv
// Receiving checker for the pakout loopback channel: verifies the data nibble count and
// dst address sequence, reports a sticky error, the first failing packet and a packet count.
module pakout_chk #(
  parameter int MIN_ADDR = 1,
  parameter int MAX_ADDR = 1,
  parameter int ASZ      = 8,
  parameter int DSZ      = 8,
  parameter int CSZ      = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  pakout_chk_if.slave    bus,
  output logic [DSZ-1:0] o_ck_dat,
  output logic           o_err,
  output logic [DSZ-1:0] o_fst_err_inp,
  output logic [DSZ-1:0] o_fst_err_dat,
  output logic [ASZ-1:0] o_fst_err_dst,
  output logic [CSZ-1:0] o_pkt_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CHK  = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  localparam logic [ASZ-1:0] MIN_A = ASZ'(MIN_ADDR);
  localparam logic [ASZ-1:0] MAX_A = ASZ'(MAX_ADDR);

  // Reset asserts asynchronously and is released on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e         state_q, state_d;
  logic           ack_q, ack_d;
  logic [ASZ-1:0] cap_src_q, cap_src_d;
  logic [ASZ-1:0] cap_dst_q, cap_dst_d;
  logic [DSZ-1:0] cap_dat_q, cap_dat_d;
  logic [DSZ-1:0] ck_dat_q, ck_dat_d;
  logic [ASZ-1:0] exp_dst_q, exp_dst_d;
  logic           err_q, err_d;
  logic           fst_flag_q, fst_flag_d;
  logic [DSZ-1:0] fst_inp_q, fst_inp_d;
  logic [DSZ-1:0] fst_dat_q, fst_dat_d;
  logic [ASZ-1:0] fst_dst_q, fst_dst_d;
  logic [CSZ-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [3:0]     exp_nib;
  logic [DSZ-1:0] exp_dat;
  logic           err_dat;
  logic           err_dst;

  // Nibble increments in 4 bits so 15 wraps to 0; upper data bits are expected zero.
  assign exp_nib = ck_dat_q[3:0] + 4'd1;
  assign exp_dat = DSZ'(exp_nib);
  assign err_dat = (cap_dat_q != exp_dat);
  assign err_dst = (cap_dst_q != exp_dst_q);

  // The source address is captured for debug visibility only.
  logic unused_src;
  assign unused_src = ^cap_src_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    ack_d      = ack_q;
    cap_src_d  = cap_src_q;
    cap_dst_d  = cap_dst_q;
    cap_dat_d  = cap_dat_q;
    ck_dat_d   = ck_dat_q;
    exp_dst_d  = exp_dst_q;
    err_d      = err_q;
    fst_flag_d = fst_flag_q;
    fst_inp_d  = fst_inp_q;
    fst_dat_d  = fst_dat_q;
    fst_dst_d  = fst_dst_q;
    pkt_cnt_d  = pkt_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i0_req) begin
          cap_src_d = bus.i0_src;
          cap_dst_d = bus.i0_dst;
          cap_dat_d = bus.i0_dat;
          state_d   = S_CHK;
        end
      end

      S_CHK: begin
        // Always follow the received packet so one glitch yields exactly one error event.
        ck_dat_d  = cap_dat_q;
        exp_dst_d = (cap_dst_q >= MAX_A) ? MIN_A : cap_dst_q + 1'b1;
        pkt_cnt_d = pkt_cnt_q + 1'b1;
        if (err_dat || err_dst) begin
          err_d = 1'b1;
          if (!fst_flag_q) begin
            fst_flag_d = 1'b1;
            fst_inp_d  = cap_dat_q;
            fst_dat_d  = exp_dat;
            fst_dst_d  = cap_dst_q;
          end
        end
        ack_d   = 1'b1;
        state_d = S_ACK;
      end

      S_ACK: begin
        if (!bus.i0_req) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ack_q      <= 1'b0;
      cap_src_q  <= '0;
      cap_dst_q  <= '0;
      cap_dat_q  <= '0;
      ck_dat_q   <= DSZ'(15);
      exp_dst_q  <= MIN_A;
      err_q      <= 1'b0;
      fst_flag_q <= 1'b0;
      fst_inp_q  <= '0;
      fst_dat_q  <= '0;
      fst_dst_q  <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      cap_src_q  <= cap_src_d;
      cap_dst_q  <= cap_dst_d;
      cap_dat_q  <= cap_dat_d;
      ck_dat_q   <= ck_dat_d;
      exp_dst_q  <= exp_dst_d;
      err_q      <= err_d;
      fst_flag_q <= fst_flag_d;
      fst_inp_q  <= fst_inp_d;
      fst_dat_q  <= fst_dat_d;
      fst_dst_q  <= fst_dst_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign bus.i0_ack    = ack_q;
  assign o_ck_dat      = ck_dat_q;
  assign o_err         = err_q;
  assign o_fst_err_inp = fst_inp_q;
  assign o_fst_err_dat = fst_dat_q;
  assign o_fst_err_dst = fst_dst_q;
  assign o_pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_pakout_chk.sv
// Directed bench for pakout_chk with MIN_ADDR=1, MAX_ADDR=3: sequence checks, error capture,
// handshake latency and mid-handshake reset.
module tb_pakout_chk;

  localparam int ASZ = 8;
  localparam int DSZ = 8;
  localparam int CSZ = 16;

  logic           i_clk;
  logic           i_rst_n;
  logic [DSZ-1:0] o_ck_dat;
  logic           o_err;
  logic [DSZ-1:0] o_fst_err_inp;
  logic [DSZ-1:0] o_fst_err_dat;
  logic [ASZ-1:0] o_fst_err_dst;
  logic [CSZ-1:0] o_pkt_cnt;

  int checks = 0;
  int errors = 0;

  pakout_chk_if #(.ASZ(ASZ), .DSZ(DSZ)) bus ();

  pakout_chk #(
    .MIN_ADDR(1), .MAX_ADDR(3), .ASZ(ASZ), .DSZ(DSZ), .CSZ(CSZ)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .bus           (bus.slave),
    .o_ck_dat      (o_ck_dat),
    .o_err         (o_err),
    .o_fst_err_inp (o_fst_err_inp),
    .o_fst_err_dat (o_fst_err_dat),
    .o_fst_err_dst (o_fst_err_dst),
    .o_pkt_cnt     (o_pkt_cnt)
  );

  initial i_clk = 1'b0;
  always #20 i_clk = ~i_clk;

  task automatic apply_reset();
    @(negedge i_clk);
    i_rst_n    = 1'b0;
    bus.i0_req = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (4) @(negedge i_clk);
  endtask

  // One full 4-phase handshake; every wait is bounded.
  task automatic send_pkt(input logic [ASZ-1:0] dst, input logic [DSZ-1:0] dat);
    bit got;
    @(negedge i_clk);
    bus.i0_src = 8'hA5;
    bus.i0_dst = dst;
    bus.i0_dat = dat;
    bus.i0_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge i_clk);
      if (bus.i0_ack === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_rise_timeout: ack=%b required 1 (dat=%0h)", bus.i0_ack, dat);
    end
    bus.i0_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge i_clk);
      if (bus.i0_ack === 1'b0) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_fall_timeout: ack=%b required 0 (dat=%0h)", bus.i0_ack, dat);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.i0_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", bus.i0_ack); end
    checks++;
    if (o_ck_dat !== 8'd15) begin errors++; $display("FAIL rst_ck_dat: got %0d want 15", o_ck_dat); end
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", o_err); end
    checks++;
    if (o_pkt_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", o_pkt_cnt); end
    checks++;
    if ({o_fst_err_inp, o_fst_err_dat, o_fst_err_dst} !== 24'd0) begin
      errors++;
      $display("FAIL rst_fst: got %0h/%0h/%0h want 0/0/0", o_fst_err_inp, o_fst_err_dat, o_fst_err_dst);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 6; i++) send_pkt(ASZ'(1 + i % 3), DSZ'(i));
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL t1_err: got %b want 0", o_err); end
    checks++;
    if (o_pkt_cnt !== 16'd6) begin errors++; $display("FAIL t1_cnt: got %0d want 6", o_pkt_cnt); end
    checks++;
    if (o_ck_dat !== 8'd5) begin errors++; $display("FAIL t1_ck_dat: got %0d want 5", o_ck_dat); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 18; i++) send_pkt(ASZ'(1 + i % 3), DSZ'(i % 16));
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL t2_err: got %b want 0", o_err); end
    checks++;
    if (o_pkt_cnt !== 16'd18) begin errors++; $display("FAIL t2_cnt: got %0d want 18", o_pkt_cnt); end
    checks++;
    if (o_ck_dat !== 8'd1) begin errors++; $display("FAIL t2_ck_dat: got %0d want 1", o_ck_dat); end
  endtask

  task automatic test_data_glitch();
    apply_reset();
    send_pkt(8'd1, 8'd0);
    send_pkt(8'd2, 8'd1);
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL t3_err_pre: got %b want 0", o_err); end
    send_pkt(8'd3, 8'd7);
    send_pkt(8'd1, 8'd8);
    checks++;
    if (o_err !== 1'b1) begin errors++; $display("FAIL t3_err: got %b want 1", o_err); end
    checks++;
    if (o_fst_err_inp !== 8'd7) begin errors++; $display("FAIL t3_fst_inp: got %0d want 7", o_fst_err_inp); end
    checks++;
    if (o_fst_err_dat !== 8'd2) begin errors++; $display("FAIL t3_fst_dat: got %0d want 2", o_fst_err_dat); end
    checks++;
    if (o_fst_err_dst !== 8'd3) begin errors++; $display("FAIL t3_fst_dst: got %0d want 3", o_fst_err_dst); end
    checks++;
    if (o_ck_dat !== 8'd8) begin errors++; $display("FAIL t3_ck_dat: got %0d want 8", o_ck_dat); end
    checks++;
    if (o_pkt_cnt !== 16'd4) begin errors++; $display("FAIL t3_cnt: got %0d want 4", o_pkt_cnt); end
  endtask

  task automatic test_dst_then_data();
    apply_reset();
    send_pkt(8'd1, 8'd0);
    send_pkt(8'd3, 8'd1);   // dst error, expected 2
    checks++;
    if ({o_err, o_fst_err_inp, o_fst_err_dat, o_fst_err_dst} !== {1'b1, 8'd1, 8'd1, 8'd3}) begin
      errors++;
      $display("FAIL t4_first: got err=%b %0d/%0d/%0d want 1 1/1/3",
               o_err, o_fst_err_inp, o_fst_err_dat, o_fst_err_dst);
    end
    send_pkt(8'd1, 8'd2);   // resynced: dst 3 wrapped to 1
    send_pkt(8'd2, 8'd3);
    send_pkt(8'd3, 8'd5);   // data skip, expected 4
    send_pkt(8'd7, 8'd6);   // out-of-range dst; next expected wraps to 1
    send_pkt(8'd1, 8'd7);
    checks++;
    if ({o_fst_err_inp, o_fst_err_dat, o_fst_err_dst} !== {8'd1, 8'd1, 8'd3}) begin
      errors++;
      $display("FAIL t4_fst_hold: got %0d/%0d/%0d want 1/1/3", o_fst_err_inp, o_fst_err_dat, o_fst_err_dst);
    end
    checks++;
    if (o_pkt_cnt !== 16'd7) begin errors++; $display("FAIL t4_cnt: got %0d want 7", o_pkt_cnt); end
    checks++;
    if (o_ck_dat !== 8'd7) begin errors++; $display("FAIL t4_ck_dat: got %0d want 7", o_ck_dat); end
  endtask

  task automatic test_handshake_timing();
    int bad_hold;
    apply_reset();
    @(negedge i_clk);
    bus.i0_dst = 8'd1;
    bus.i0_dat = 8'd0;
    bus.i0_req = 1'b1;
    @(negedge i_clk);
    checks++;
    if (bus.i0_ack !== 1'b0) begin errors++; $display("FAIL t5_ack_cyc1: got %b want 0", bus.i0_ack); end
    @(negedge i_clk);
    checks++;
    if (bus.i0_ack !== 1'b1) begin errors++; $display("FAIL t5_ack_cyc2: got %b want 1", bus.i0_ack); end
    bad_hold = 0;
    for (int i = 0; i < 8; i++) begin
      bus.i0_dat = DSZ'(8'h40 + i);   // ignored while req is high
      @(negedge i_clk);
      if (bus.i0_ack !== 1'b1) bad_hold++;
    end
    checks++;
    if (bad_hold != 0) begin errors++; $display("FAIL t5_ack_hold: ack low in %0d cycles want 0", bad_hold); end
    bus.i0_req = 1'b0;
    @(negedge i_clk);
    checks++;
    if (bus.i0_ack !== 1'b0) begin errors++; $display("FAIL t5_ack_fall: got %b want 0", bus.i0_ack); end
    repeat (2) @(negedge i_clk);
    checks++;
    if ({o_pkt_cnt, o_err, o_ck_dat} !== {16'd1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL t5_result: got cnt=%0d err=%b ck=%0d want 1 0 0", o_pkt_cnt, o_err, o_ck_dat);
    end
  endtask

  task automatic test_reset_mid_handshake();
    apply_reset();
    send_pkt(8'd2, 8'd0);   // bad dst so state is non-reset
    checks++;
    if (o_err !== 1'b1) begin errors++; $display("FAIL t6_pre_err: got %b want 1", o_err); end
    @(negedge i_clk);
    bus.i0_dst = 8'd2;
    bus.i0_dat = 8'd1;
    bus.i0_req = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++;
    if (bus.i0_ack !== 1'b1) begin errors++; $display("FAIL t6_ack_up: got %b want 1", bus.i0_ack); end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (bus.i0_ack !== 1'b0) begin errors++; $display("FAIL t6_ack_async: got %b want 0", bus.i0_ack); end
    checks++;
    if ({o_err, o_pkt_cnt, o_ck_dat, o_fst_err_inp, o_fst_err_dat, o_fst_err_dst} !==
        {1'b0, 16'd0, 8'd15, 24'd0}) begin
      errors++;
      $display("FAIL t6_outputs: got err=%b cnt=%0d ck=%0d fst=%0h/%0h/%0h want 0 0 15 0/0/0",
               o_err, o_pkt_cnt, o_ck_dat, o_fst_err_inp, o_fst_err_dat, o_fst_err_dst);
    end
    bus.i0_req = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (4) @(negedge i_clk);
    send_pkt(8'd1, 8'd0);
    checks++;
    if ({o_err, o_pkt_cnt, o_ck_dat} !== {1'b0, 16'd1, 8'd0}) begin
      errors++;
      $display("FAIL t6_after: got err=%b cnt=%0d ck=%0d want 0 1 0", o_err, o_pkt_cnt, o_ck_dat);
    end
    send_pkt(8'd2, 8'h11);  // low nibble right, upper bits nonzero
    checks++;
    if ({o_err, o_fst_err_inp, o_fst_err_dat, o_fst_err_dst} !== {1'b1, 8'h11, 8'h01, 8'd2}) begin
      errors++;
      $display("FAIL t6_upper_bits: got err=%b %0h/%0h/%0h want 1 11/1/2",
               o_err, o_fst_err_inp, o_fst_err_dat, o_fst_err_dst);
    end
    send_pkt(8'd3, 8'd2);
    checks++;
    if ({o_pkt_cnt, o_ck_dat, o_fst_err_inp} !== {16'd3, 8'd2, 8'h11}) begin
      errors++;
      $display("FAIL t6_resync: got cnt=%0d ck=%0d fst_inp=%0h want 3 2 11", o_pkt_cnt, o_ck_dat, o_fst_err_inp);
    end
  endtask

  initial begin
    i_rst_n    = 1'b0;
    bus.i0_src = '0;
    bus.i0_dst = '0;
    bus.i0_dat = '0;
    bus.i0_req = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_data_glitch();
    test_dst_then_data();
    test_handshake_timing();
    test_reset_mid_handshake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
